// File: rtl/wb_arbiter_pkg.sv
// Shared core definitions for the writeback arbiter: widths, requester IDs
// and the two-way round-robin pick function.
package wb_arbiter_pkg;

  localparam int XLEN_DEF = 32;
  localparam int REG_AW   = 5;

  typedef enum logic {
    REQ_ALU = 1'b0,
    REQ_LSU = 1'b1
  } req_id_e;

  // A lone requester always wins; on a tie the favoured requester wins.
  function automatic logic [1:0] rr_pick(input logic [1:0] req, input req_id_e favour);
    logic [1:0] g;
    g = 2'b00;
    case (req)
      2'b01:   g = 2'b01;
      2'b10:   g = 2'b10;
      2'b11:   g = (favour == REQ_ALU) ? 2'b01 : 2'b10;
      default: g = 2'b00;
    endcase
    return g;
  endfunction

endpackage

// File: rtl/wb_arbiter_if.sv
// Writeback bus between the ALU/load-unit requesters, the arbiter and the
// register-file write port.
interface wb_arbiter_if #(
  parameter int XLEN = wb_arbiter_pkg::XLEN_DEF
);
  import wb_arbiter_pkg::*;

  logic              alu_valid;
  logic [REG_AW-1:0] alu_rd;
  logic [XLEN-1:0]   alu_data;
  logic              alu_ready;

  logic              lsu_valid;
  logic [REG_AW-1:0] lsu_rd;
  logic [XLEN-1:0]   lsu_data;
  logic              lsu_ready;

  logic              reg_write;
  logic [REG_AW-1:0] rd;
  logic [XLEN-1:0]   rd_data;

  modport master (
    output alu_valid, alu_rd, alu_data,
    output lsu_valid, lsu_rd, lsu_data,
    input  alu_ready, lsu_ready,
    input  reg_write, rd, rd_data
  );

  modport slave (
    input  alu_valid, alu_rd, alu_data,
    input  lsu_valid, lsu_rd, lsu_data,
    output alu_ready, lsu_ready,
    output reg_write, rd, rd_data
  );

endinterface

// File: rtl/wb_arbiter_rr_arb2.sv
// Two-way round-robin arbiter: grant is combinational from req and the
// favour pointer, which flips to the other requester after every grant.
module rr_arb2
  import wb_arbiter_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  output logic [1:0] grant
);

  req_id_e favour_q;
  req_id_e favour_d;

  // Grants are suppressed while reset is held so nothing is accepted.
  always_comb begin
    grant = 2'b00;
    if (rst_n) begin
      grant = rr_pick(req, favour_q);
    end
  end

  always_comb begin
    favour_d = favour_q;
    if (grant[0]) begin
      favour_d = REQ_LSU;
    end else if (grant[1]) begin
      favour_d = REQ_ALU;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      favour_q <= REQ_ALU;
    end else begin
      favour_q <= favour_d;
    end
  end

endmodule

// File: rtl/wb_arbiter.sv
// Writeback arbiter: picks one of ALU/LSU per cycle, registers the winner
// into the register-file write stage and counts contended cycles.
module wb_arbiter
  import wb_arbiter_pkg::*;
#(
  parameter int XLEN  = XLEN_DEF,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  wb_arbiter_if.slave      bus,
  output logic [CNT_W-1:0] conflict_cnt
);

  logic [1:0]        grant;
  logic              accept;
  logic              both_valid;
  logic [REG_AW-1:0] sel_rd;
  logic [XLEN-1:0]   sel_data;

  logic              wr_q;
  logic [REG_AW-1:0] rd_q;
  logic [XLEN-1:0]   data_q;

  rr_arb2 u_arb (
    .clk   (clk),
    .rst_n (rst_n),
    .req   ({bus.lsu_valid, bus.alu_valid}),
    .grant (grant)
  );

  assign bus.alu_ready = grant[0];
  assign bus.lsu_ready = grant[1];

  always_comb begin
    accept     = grant[0] | grant[1];
    both_valid = bus.alu_valid & bus.lsu_valid;
    sel_rd     = bus.alu_rd;
    sel_data   = bus.alu_data;
    if (grant[1]) begin
      sel_rd   = bus.lsu_rd;
      sel_data = bus.lsu_data;
    end
  end

  // Writes to x0 still complete the handshake but never reach the register file.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_q   <= 1'b0;
      rd_q   <= '0;
      data_q <= '0;
    end else begin
      wr_q <= accept && (sel_rd != '0);
      if (accept) begin
        rd_q   <= sel_rd;
        data_q <= sel_data;
      end
    end
  end

  assign bus.reg_write = wr_q;
  assign bus.rd        = rd_q;
  assign bus.rd_data   = data_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      conflict_cnt <= '0;
    end else if (both_valid && (conflict_cnt != '1)) begin
      conflict_cnt <= conflict_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_wb_arbiter.sv
// Directed testbench for wb_arbiter: hand-computed vectors checked with
// immediate assertions, plus a CNT_W=4 instance for counter saturation.
module tb_wb_arbiter;

  logic        clk;
  logic        rst_n;
  logic [15:0] conflict_cnt;
  logic [3:0]  conflict_cnt4;

  int checks   = 0;
  int failures = 0;

  wb_arbiter_if #(.XLEN(32)) bus ();
  wb_arbiter_if #(.XLEN(32)) bus4 ();

  // The narrow-counter instance sees exactly the same requests.
  assign bus4.alu_valid = bus.alu_valid;
  assign bus4.alu_rd    = bus.alu_rd;
  assign bus4.alu_data  = bus.alu_data;
  assign bus4.lsu_valid = bus.lsu_valid;
  assign bus4.lsu_rd    = bus.lsu_rd;
  assign bus4.lsu_data  = bus.lsu_data;

  wb_arbiter #(.XLEN(32), .CNT_W(16)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .bus          (bus),
    .conflict_cnt (conflict_cnt)
  );

  wb_arbiter #(.XLEN(32), .CNT_W(4)) dut4 (
    .clk          (clk),
    .rst_n        (rst_n),
    .bus          (bus4),
    .conflict_cnt (conflict_cnt4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic applyStimulus(input logic av, input logic [4:0] ard, input logic [31:0] adata,
                               input logic lv, input logic [4:0] lrd, input logic [31:0] ldata);
    bus.alu_valid = av;
    bus.alu_rd    = ard;
    bus.alu_data  = adata;
    bus.lsu_valid = lv;
    bus.lsu_rd    = lrd;
    bus.lsu_data  = ldata;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      failures++;
      $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, observed, expected);
    end
  endtask

  task automatic resetDut();
    applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    rst_n = 1'b0;
    @(posedge clk);
    #3;
    rst_n = 1'b1;
  endtask

  initial begin
    int  alu_n;
    int  lsu_n;
    logic alu_wins;

    // Reset state, with a valid request pending that must not be granted
    rst_n = 1'b0;
    applyStimulus(1'b1, 5'd5, 32'hDEADBEEF, 1'b1, 5'd6, 32'h0);
    #2;
    checkOutput("rst_alu_ready", 32'(bus.alu_ready), 32'h0);
    checkOutput("rst_lsu_ready", 32'(bus.lsu_ready), 32'h0);
    checkOutput("rst_reg_write", 32'(bus.reg_write), 32'h0);
    checkOutput("rst_rd",        32'(bus.rd),        32'h0);
    checkOutput("rst_rd_data",   bus.rd_data,        32'h0);
    checkOutput("rst_cnt",       32'(conflict_cnt),  32'h0);
    applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    #10;
    rst_n = 1'b1;

    // ALU alone, accepted on the first edge after reset release
    applyStimulus(1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 32'h0);
    #1;
    checkOutput("alu_only_ready",     32'(bus.alu_ready), 32'h1);
    checkOutput("alu_only_lsu_ready", 32'(bus.lsu_ready), 32'h0);
    @(posedge clk); #1;
    checkOutput("alu_only_write", 32'(bus.reg_write), 32'h1);
    checkOutput("alu_only_rd",    32'(bus.rd),        32'h5);
    checkOutput("alu_only_data",  bus.rd_data,        32'hDEADBEEF);
    applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    @(posedge clk); #1;
    checkOutput("idle_write", 32'(bus.reg_write), 32'h0);

    // First tie after reset goes to ALU, LSU follows
    resetDut();
    applyStimulus(1'b1, 5'd1, 32'h11, 1'b1, 5'd2, 32'h22);
    #1;
    checkOutput("tie0_alu_ready", 32'(bus.alu_ready), 32'h1);
    checkOutput("tie0_lsu_ready", 32'(bus.lsu_ready), 32'h0);
    @(posedge clk); #1;
    checkOutput("tie0_write", 32'(bus.reg_write), 32'h1);
    checkOutput("tie0_rd",    32'(bus.rd),        32'h1);
    checkOutput("tie0_data",  bus.rd_data,        32'h11);
    applyStimulus(1'b0, 5'd0, 32'h0, 1'b1, 5'd2, 32'h22);
    #1;
    checkOutput("tie1_lsu_ready", 32'(bus.lsu_ready), 32'h1);
    @(posedge clk); #1;
    checkOutput("tie1_write", 32'(bus.reg_write), 32'h1);
    checkOutput("tie1_rd",    32'(bus.rd),        32'h2);
    checkOutput("tie1_data",  bus.rd_data,        32'h22);
    checkOutput("tie_cnt",    32'(conflict_cnt),  32'h1);
    applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);

    // Sustained contention alternates ALU, LSU, ALU, ... with a write every cycle
    resetDut();
    alu_n = 0;
    lsu_n = 0;
    for (int i = 0; i < 6; i++) begin
      applyStimulus(1'b1, 5'(10 + alu_n), 32'hA0 + 32'(alu_n),
                    1'b1, 5'(20 + lsu_n), 32'hB0 + 32'(lsu_n));
      #1;
      alu_wins = (i % 2 == 0);
      checkOutput($sformatf("alt%0d_alu_ready", i), 32'(bus.alu_ready), 32'(alu_wins));
      checkOutput($sformatf("alt%0d_lsu_ready", i), 32'(bus.lsu_ready), 32'(!alu_wins));
      @(posedge clk); #1;
      checkOutput($sformatf("alt%0d_write", i), 32'(bus.reg_write), 32'h1);
      if (alu_wins) begin
        checkOutput($sformatf("alt%0d_rd", i),   32'(bus.rd), 32'(10 + alu_n));
        checkOutput($sformatf("alt%0d_data", i), bus.rd_data, 32'hA0 + 32'(alu_n));
        alu_n++;
      end else begin
        checkOutput($sformatf("alt%0d_rd", i),   32'(bus.rd), 32'(20 + lsu_n));
        checkOutput($sformatf("alt%0d_data", i), bus.rd_data, 32'hB0 + 32'(lsu_n));
        lsu_n++;
      end
    end
    applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    checkOutput("alt_cnt", 32'(conflict_cnt), 32'h6);

    // A write to x0 completes the handshake but does not write
    applyStimulus(1'b0, 5'd0, 32'h0, 1'b1, 5'd0, 32'h12345678);
    #1;
    checkOutput("x0_lsu_ready", 32'(bus.lsu_ready), 32'h1);
    @(posedge clk); #1;
    checkOutput("x0_write", 32'(bus.reg_write), 32'h0);
    applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);

    // Reset arriving while a write is in the output stage discards it at once
    applyStimulus(1'b1, 5'd7, 32'h77, 1'b0, 5'd0, 32'h0);
    #1;
    checkOutput("mid_alu_ready", 32'(bus.alu_ready), 32'h1);
    @(posedge clk); #1;
    checkOutput("mid_pre_write", 32'(bus.reg_write), 32'h1);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("mid_write_dropped", 32'(bus.reg_write), 32'h0);
    checkOutput("mid_rd_cleared",    32'(bus.rd),        32'h0);
    checkOutput("mid_alu_ready_rst", 32'(bus.alu_ready), 32'h0);
    @(posedge clk); #1;
    checkOutput("mid_write_held",    32'(bus.reg_write), 32'h0);
    checkOutput("mid_alu_ready_hold", 32'(bus.alu_ready), 32'h0);
    rst_n = 1'b1;
    #1;
    checkOutput("mid_alu_ready_rel", 32'(bus.alu_ready), 32'h1);
    applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);

    // Narrow counter saturates at all-ones while the wide one keeps counting
    resetDut();
    applyStimulus(1'b1, 5'd3, 32'h33, 1'b1, 5'd4, 32'h44);
    repeat (15) @(posedge clk);
    #1;
    checkOutput("sat_cnt4_15", 32'(conflict_cnt4), 32'hF);
    repeat (5) @(posedge clk);
    #1;
    checkOutput("sat_cnt4_20", 32'(conflict_cnt4), 32'hF);
    checkOutput("sat_cnt16_20", 32'(conflict_cnt), 32'd20);
    applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
